// File: rtl/mig_arb_pkg.sv
// Shared types and constants for the MIG port arbiter: FSM states, MIG command codes,
// and the client-index width helper.
package mig_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        DRAIN   = 2'd2,
        RELEASE = 2'd3
    } arb_state_e;

    localparam logic [2:0] CMD_WR = 3'd0;
    localparam logic [2:0] CMD_RD = 3'd1;

    // Never returns less than 1 so a client index always has at least one bit.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/mig_arb_tag_fifo.sv
// Client-index tag FIFO: records the issuer of each read so returning data can be routed.
// Zero-latency head; push is accepted while full only if a pop happens in the same cycle.
module mig_arb_tag_fifo #(
    parameter int DEPTH = 32,
    parameter int W     = 1
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         push_i,
    input  logic [W-1:0] push_dat_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q;
    logic [AW:0]  rd_ptr_q;
    logic         do_push;
    logic         do_pop;

    // Extra pointer MSB distinguishes full from empty when the address bits match.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
    end

endmodule

// File: rtl/mig_port_arbiter.sv
// Shares one MIG app_* port among NUM_CLIENTS; round-robin burst grants, 1-cycle arbitration,
// command/write mux is combinational, read data routed by tag FIFO; full tag FIFO stalls reads only.
module mig_port_arbiter
    import mig_arb_pkg::*;
#(
    parameter int NUM_CLIENTS        = 2,
    parameter int MIG_Data_Port_Size = 128,
    parameter int MIG_Addr_Port_Size = 28,
    parameter int Tag_Fifo_Depth     = 32,
    parameter int Max_Grant_Cmds     = 64
) (
    input  logic                                         aclk,
    input  logic                                         aresetn,
    input  logic                                         init_calib,
    input  logic [NUM_CLIENTS-1:0]                       c_req,
    output logic [NUM_CLIENTS-1:0]                       c_grant,
    input  logic [NUM_CLIENTS-1:0]                       c_cmd_last,
    input  logic [NUM_CLIENTS*MIG_Addr_Port_Size-1:0]    c_app_addr,
    input  logic [NUM_CLIENTS*3-1:0]                     c_app_cmd,
    input  logic [NUM_CLIENTS-1:0]                       c_app_en,
    output logic [NUM_CLIENTS-1:0]                       c_app_rdy,
    input  logic [NUM_CLIENTS*MIG_Data_Port_Size-1:0]    c_app_wdf_data,
    input  logic [NUM_CLIENTS-1:0]                       c_app_wdf_wren,
    input  logic [NUM_CLIENTS-1:0]                       c_app_wdf_end,
    output logic [NUM_CLIENTS-1:0]                       c_app_wdf_rdy,
    output logic [MIG_Data_Port_Size-1:0]                c_rd_data,
    output logic [NUM_CLIENTS-1:0]                       c_rd_data_valid,
    output logic [NUM_CLIENTS-1:0]                       c_rd_data_end,
    output logic [MIG_Addr_Port_Size-1:0]                app_addr,
    output logic [2:0]                                   app_cmd,
    output logic                                         app_en,
    input  logic                                         app_rdy,
    output logic [MIG_Data_Port_Size-1:0]                app_wdf_data,
    output logic                                         app_wdf_wren,
    output logic                                         app_wdf_end,
    input  logic                                         app_wdf_rdy,
    input  logic [MIG_Data_Port_Size-1:0]                app_rd_data,
    input  logic                                         app_rd_data_valid,
    input  logic                                         app_rd_data_end,
    output logic                                         err_orphan_rd
);

    localparam int IW = clog2(NUM_CLIENTS);
    localparam int GW = $clog2(Max_Grant_Cmds + 1);
    localparam int PW = $clog2(2 * Max_Grant_Cmds + 1);

    arb_state_e              state_q, state_d;
    logic [IW-1:0]           gnt_idx_q, gnt_idx_d;
    logic [IW-1:0]           rr_q, rr_d;
    logic [GW-1:0]           gcnt_q, gcnt_d;
    logic [PW-1:0]           pend_q, pend_d;
    logic                    orphan_q;
    logic [IW-1:0]           pick;

    logic [MIG_Addr_Port_Size-1:0] addr_a  [NUM_CLIENTS];
    logic [2:0]                    cmd_a   [NUM_CLIENTS];
    logic [MIG_Data_Port_Size-1:0] wdata_a [NUM_CLIENTS];

    for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_unpack
        assign addr_a[i]  = c_app_addr[i*MIG_Addr_Port_Size +: MIG_Addr_Port_Size];
        assign cmd_a[i]   = c_app_cmd[i*3 +: 3];
        assign wdata_a[i] = c_app_wdf_data[i*MIG_Data_Port_Size +: MIG_Data_Port_Size];
    end

    logic          granted, cmd_open, is_rd, is_wr, rd_blk, cmd_acc, wend_acc;
    logic          tag_pop, tag_full, tag_empty;
    logic [IW-1:0] tag_head;

    assign granted  = (state_q == GRANT) || (state_q == DRAIN);
    assign cmd_open = (state_q == GRANT);
    assign is_rd    = (cmd_a[gnt_idx_q] == CMD_RD);
    assign is_wr    = (cmd_a[gnt_idx_q] == CMD_WR);
    assign tag_pop  = app_rd_data_valid && app_rd_data_end;
    // A read may still be taken at full occupancy when a tag retires this same cycle.
    assign rd_blk   = is_rd && tag_full && !tag_pop;

    assign app_addr     = addr_a[gnt_idx_q];
    assign app_cmd      = cmd_a[gnt_idx_q];
    assign app_wdf_data = wdata_a[gnt_idx_q];
    assign app_en       = cmd_open && c_app_en[gnt_idx_q] && !rd_blk;
    assign app_wdf_wren = granted && c_app_wdf_wren[gnt_idx_q];
    assign app_wdf_end  = granted && c_app_wdf_end[gnt_idx_q];
    assign cmd_acc      = app_en && app_rdy;
    assign wend_acc     = app_wdf_wren && app_wdf_end && app_wdf_rdy;

    assign c_rd_data     = app_rd_data;
    assign err_orphan_rd = orphan_q;

    always_comb begin
        c_grant         = '0;
        c_app_rdy       = '0;
        c_app_wdf_rdy   = '0;
        c_rd_data_valid = '0;
        c_rd_data_end   = '0;
        if (granted) begin
            c_grant[gnt_idx_q]       = 1'b1;
            c_app_wdf_rdy[gnt_idx_q] = app_wdf_rdy;
        end
        if (cmd_open) c_app_rdy[gnt_idx_q] = app_rdy && !rd_blk;
        if (!tag_empty) begin
            c_rd_data_valid[tag_head] = app_rd_data_valid;
            c_rd_data_end[tag_head]   = app_rd_data_end;
        end
    end

    // First requester at or after the round-robin pointer.
    always_comb begin
        logic          found;
        logic [IW-1:0] cand;
        pick  = rr_q;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            cand = IW'((int'(rr_q) + i) % NUM_CLIENTS);
            if (!found && c_req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        pend_d = pend_q;
        case ({cmd_acc && is_wr, wend_acc})
            2'b10:   pend_d = pend_q + PW'(1);
            2'b01:   pend_d = pend_q - PW'(1);
            default: pend_d = pend_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        gnt_idx_d = gnt_idx_q;
        rr_d      = rr_q;
        gcnt_d    = gcnt_q;
        case (state_q)
            IDLE: begin
                if (init_calib && (|c_req)) begin
                    gnt_idx_d = pick;
                    gcnt_d    = '0;
                    state_d   = GRANT;
                end
            end
            GRANT: begin
                if (cmd_acc) begin
                    gcnt_d = gcnt_q + GW'(1);
                    if (c_cmd_last[gnt_idx_q] || (gcnt_q == GW'(Max_Grant_Cmds - 1)))
                        state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pend_d == '0) state_d = RELEASE;
            end
            RELEASE: begin
                rr_d    = (gnt_idx_q == IW'(NUM_CLIENTS - 1)) ? '0 : gnt_idx_q + IW'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            gnt_idx_q <= '0;
            rr_q      <= '0;
            gcnt_q    <= '0;
            pend_q    <= '0;
            orphan_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_idx_q <= gnt_idx_d;
            rr_q      <= rr_d;
            gcnt_q    <= gcnt_d;
            pend_q    <= pend_d;
            if (app_rd_data_valid && tag_empty) orphan_q <= 1'b1;
        end
    end

    mig_arb_tag_fifo #(
        .DEPTH (Tag_Fifo_Depth),
        .W     (IW)
    ) u_tag_fifo (
        .clk_i      (aclk),
        .rst_n_i    (aresetn),
        .push_i     (cmd_acc && is_rd),
        .push_dat_i (gnt_idx_q),
        .pop_i      (tag_pop),
        .head_o     (tag_head),
        .full_o     (tag_full),
        .empty_o    (tag_empty)
    );

endmodule

// File: tb/tb_mig_port_arbiter.sv
// Bench for mig_port_arbiter: directed write/fill/limit/orphan steps, then randomized read
// traffic checked against a queue-based owner model and round-robin grant schedule.
module tb_mig_port_arbiter;
    import mig_arb_pkg::*;

    localparam int NC = 2, DW = 32, AW = 28, DEPTH = 4, MGC = 8;

    logic              aclk = 1'b0;
    logic              aresetn, init_calib;
    logic [NC-1:0]     c_req, c_grant, c_cmd_last, c_app_en, c_app_rdy;
    logic [NC-1:0]     c_app_wdf_wren, c_app_wdf_end, c_app_wdf_rdy;
    logic [NC-1:0]     c_rd_data_valid, c_rd_data_end;
    logic [NC*AW-1:0]  c_app_addr;
    logic [NC*3-1:0]   c_app_cmd;
    logic [NC*DW-1:0]  c_app_wdf_data;
    logic [DW-1:0]     c_rd_data, app_wdf_data, app_rd_data;
    logic [AW-1:0]     app_addr;
    logic [2:0]        app_cmd;
    logic              app_en, app_rdy, app_wdf_wren, app_wdf_end, app_wdf_rdy;
    logic              app_rd_data_valid, app_rd_data_end, err_orphan_rd;

    int n_chk = 0;
    int n_fail = 0;

    mig_port_arbiter #(
        .NUM_CLIENTS(NC), .MIG_Data_Port_Size(DW), .MIG_Addr_Port_Size(AW),
        .Tag_Fifo_Depth(DEPTH), .Max_Grant_Cmds(MGC)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .init_calib(init_calib),
        .c_req(c_req), .c_grant(c_grant), .c_cmd_last(c_cmd_last),
        .c_app_addr(c_app_addr), .c_app_cmd(c_app_cmd), .c_app_en(c_app_en),
        .c_app_rdy(c_app_rdy), .c_app_wdf_data(c_app_wdf_data),
        .c_app_wdf_wren(c_app_wdf_wren), .c_app_wdf_end(c_app_wdf_end),
        .c_app_wdf_rdy(c_app_wdf_rdy), .c_rd_data(c_rd_data),
        .c_rd_data_valid(c_rd_data_valid), .c_rd_data_end(c_rd_data_end),
        .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
        .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
        .app_wdf_rdy(app_wdf_rdy), .app_rd_data(app_rd_data),
        .app_rd_data_valid(app_rd_data_valid), .app_rd_data_end(app_rd_data_end),
        .err_orphan_rd(err_orphan_rd)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge aclk);
        #1;
    endtask

    task automatic clr_inputs();
        c_req = '0; c_cmd_last = '0; c_app_en = '0; c_app_addr = '0; c_app_cmd = '0;
        c_app_wdf_data = '0; c_app_wdf_wren = '0; c_app_wdf_end = '0;
        app_rd_data_valid = 1'b0; app_rd_data_end = 1'b0; app_rd_data = '0;
    endtask

    task automatic do_reset();
        clr_inputs();
        aresetn = 1'b0;
        repeat (3) next();
        aresetn = 1'b1;
    endtask

    int  cmds, beats;
    int  q[$];
    int  post, g_m, blen, issued;
    bit  active, ret, blk, exp_en;
    logic [NC-1:0] exp_gnt, exp_rdy, exp_rv;

    initial begin
        init_calib = 1'b0; app_rdy = 1'b0; app_wdf_rdy = 1'b0;
        do_reset();

        // Reset state
        @(negedge aclk);
        chk("rst_grant", c_grant, 0);
        chk("rst_err", err_orphan_rd, 0);
        chk("rst_app_en", app_en, 0);
        chk("rst_c_app_rdy", c_app_rdy, 0);
        chk("rst_c_wdf_rdy", c_app_wdf_rdy, 0);
        chk("rst_rd_valid", c_rd_data_valid, 0);
        next();

        // Client 0: 4-command write burst, data lagging 3 cycles
        init_calib = 1'b1; app_rdy = 1'b1; app_wdf_rdy = 1'b1; c_req = 2'b01;
        @(negedge aclk);
        chk("wr_arb_cycle", c_grant, 0);
        next();
        cmds = 0; beats = 0;
        for (int k = 0; k < 8; k++) begin
            c_app_en[0] = (k < 4);
            c_app_cmd[2:0] = CMD_WR;
            c_app_addr[AW-1:0] = AW'(100 + k);
            c_cmd_last[0] = (k == 3);
            c_app_wdf_wren[0] = (k >= 3 && k <= 6);
            c_app_wdf_end[0] = (k >= 3 && k <= 6);
            c_app_wdf_data[DW-1:0] = DW'(k - 3);
            @(negedge aclk);
            chk($sformatf("wr_grant_%0d", k), c_grant, (k <= 6) ? 1 : 0);
            chk($sformatf("wr_rdy_%0d", k), c_app_rdy, (k <= 3) ? 1 : 0);
            chk($sformatf("wr_app_en_%0d", k), app_en, (k <= 3) ? 1 : 0);
            if (k <= 3) chk($sformatf("wr_addr_%0d", k), app_addr, 100 + k);
            if (k >= 3 && k <= 6) chk($sformatf("wr_wdata_%0d", k), app_wdf_data, k - 3);
            cmds  += int'(app_en && app_rdy);
            beats += int'(app_wdf_wren && app_wdf_end && app_wdf_rdy);
            next();
        end
        chk("wr_cmd_count", cmds, 4);
        chk("wr_beat_count", beats, 4);

        // Tag FIFO fill: depth 4, client 0 keeps issuing reads
        do_reset();
        c_req = 2'b01;
        next();
        for (int k = 0; k < 8; k++) begin
            c_app_en[0] = 1'b1;
            c_app_cmd[2:0] = CMD_RD;
            c_app_addr[AW-1:0] = AW'(k);
            app_rd_data_valid = (k == 6);
            app_rd_data_end = (k == 6);
            app_rd_data = 32'hA5A5_0006;
            @(negedge aclk);
            chk($sformatf("fill_rdy_%0d", k), c_app_rdy, (k < 4 || k == 6) ? 1 : 0);
            chk($sformatf("fill_app_en_%0d", k), app_en, (k < 4 || k == 6) ? 1 : 0);
            chk($sformatf("fill_rd_valid_%0d", k), c_rd_data_valid, (k == 6) ? 1 : 0);
            if (k == 6) chk("fill_rd_data", c_rd_data, 32'hA5A5_0006);
            next();
        end

        // Reset discards outstanding tags: a return now is an orphan
        do_reset();
        app_rd_data_valid = 1'b1; app_rd_data_end = 1'b1;
        @(negedge aclk);
        chk("orphan_rd_valid", c_rd_data_valid, 0);
        chk("orphan_err_pre", err_orphan_rd, 0);
        next();
        app_rd_data_valid = 1'b0; app_rd_data_end = 1'b0;
        @(negedge aclk);
        chk("orphan_err_set", err_orphan_rd, 1);
        next();
        repeat (3) next();
        @(negedge aclk);
        chk("orphan_err_sticky", err_orphan_rd, 1);
        next();

        // No grant before calibration; then client 0 never asserts last
        do_reset();
        init_calib = 1'b0; c_req = 2'b11;
        for (int k = 0; k < 2; k++) begin
            @(negedge aclk);
            chk($sformatf("nocal_grant_%0d", k), c_grant, 0);
            next();
        end
        init_calib = 1'b1;
        next();
        for (int k = 0; k < 12; k++) begin
            c_app_en[0] = (k < 9);
            c_app_cmd[2:0] = CMD_WR;
            c_app_wdf_wren[0] = (k < 8);
            c_app_wdf_end[0] = (k < 8);
            @(negedge aclk);
            chk($sformatf("limit_grant_%0d", k), c_grant, (k <= 8) ? 2'b01 : (k == 11) ? 2'b10 : 2'b00);
            chk($sformatf("limit_app_en_%0d", k), app_en, (k < 8) ? 1 : 0);
            next();
        end

        // Randomized read traffic, both clients requesting continuously
        do_reset();
        c_req = 2'b11;
        q.delete();
        post = 3; g_m = 1; active = 1'b0; blen = 1; issued = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (post == 4) begin
                g_m = (g_m + 1) % NC;
                post = 0; active = 1'b1; issued = 0;
                blen = int'($urandom_range(1, 4));
            end
            exp_gnt = (post <= 1) ? (NC'(1) << g_m) : '0;
            app_rdy = ($urandom % 4) != 0;
            ret = (q.size() > 0) && (($urandom % 3) == 0);
            app_rd_data_valid = ret; app_rd_data_end = ret;
            app_rd_data = $urandom;
            c_app_en = '0; c_cmd_last = '0;
            c_app_cmd = {CMD_RD, CMD_RD};
            c_app_addr = (NC*AW)'({$urandom, $urandom});
            if (active) begin
                c_app_en[g_m] = ($urandom % 4) != 0;
                c_cmd_last[g_m] = (issued == blen - 1);
            end
            blk = (q.size() >= DEPTH) && !ret;
            exp_en = active && c_app_en[g_m] && !blk;
            exp_rdy = (active && app_rdy && !blk) ? (NC'(1) << g_m) : '0;
            exp_rv = ret ? (NC'(1) << q[0]) : '0;
            @(negedge aclk);
            chk($sformatf("rnd_grant_%0d", cyc), c_grant, exp_gnt);
            chk($sformatf("rnd_rdy_%0d", cyc), c_app_rdy, exp_rdy);
            chk($sformatf("rnd_app_en_%0d", cyc), app_en, exp_en);
            chk($sformatf("rnd_rd_valid_%0d", cyc), c_rd_data_valid, exp_rv);
            chk($sformatf("rnd_rd_end_%0d", cyc), c_rd_data_end, exp_rv);
            if (ret) void'(q.pop_front());
            if (exp_en && app_rdy) begin
                q.push_back(g_m);
                if (issued == blen - 1) begin
                    active = 1'b0;
                    post = 1;
                end else begin
                    issued++;
                end
            end else if (post >= 1) begin
                post++;
            end
            next();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mig_port_arbiter.md
Name: mig_port_arbiter

Overview:
- Shares one MIG native (app_*) interface between NUM_CLIENTS FIFO-style controllers.
- Each client presents the same signals it would drive to MIG directly; the arbiter grants whole bursts round-robin and muxes command/write-data.
- Read data is routed back to the issuing client by a client-index tag FIFO.
- Sits between the client controllers and the MIG UI, all in the aclk (ui_clk) domain.

Parameters:
NUM_CLIENTS, 2, number of requesters (2..4)
MIG_Data_Port_Size, 128, app data width
MIG_Addr_Port_Size, 28, app address width
Tag_Fifo_Depth, 32, max outstanding read commands (power of 2)
Max_Grant_Cmds, 64, forced grant release after this many accepted commands (fairness)

Ports:
aclk  in  1  clock
aresetn  in  1  synchronous active-low reset
init_calib  in  1  MIG calibration done; no grant issued while low
c_req  in  NUM_CLIENTS  client requests burst ownership
c_grant  out  NUM_CLIENTS  one-hot ownership
c_cmd_last  in  NUM_CLIENTS  qualifies c_app_en: final command of burst
c_app_addr  in  NUM_CLIENTS*MIG_Addr_Port_Size  flattened, client 0 in LSBs
c_app_cmd  in  NUM_CLIENTS*3  0=write, 1=read
c_app_en  in  NUM_CLIENTS  command valid
c_app_rdy  out  NUM_CLIENTS  app_rdy gated to granted client
c_app_wdf_data  in  NUM_CLIENTS*MIG_Data_Port_Size  write data
c_app_wdf_wren / c_app_wdf_end  in  NUM_CLIENTS each  write strobes
c_app_wdf_rdy  out  NUM_CLIENTS  app_wdf_rdy gated to granted client
c_rd_data  out  MIG_Data_Port_Size  broadcast app_rd_data
c_rd_data_valid / c_rd_data_end  out  NUM_CLIENTS each  routed to tag owner
app_addr, app_cmd, app_en, app_rdy, app_wdf_data, app_wdf_wren, app_wdf_end, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end  MIG side, same widths/directions as MIG UI
err_orphan_rd  out  1  sticky: read data arrived with tag FIFO empty

Behaviour:
- Reset: state IDLE, c_grant=0, rr pointer=0, pending write counter=0, grant command counter=0, tag FIFO empty, err_orphan_rd=0.
- Outputs forced low in IDLE/RELEASE: app_en, app_wdf_wren, app_wdf_end, c_app_rdy, c_app_wdf_rdy.
- FSM:
  - IDLE: if init_calib and any c_req, select the first requester at or after the rr pointer and go to GRANT next cycle (1-cycle arbitration latency).
  - GRANT: c_grant[g]=1; app_* driven combinationally from client g; app_rdy/app_wdf_rdy forwarded only to g.
  - GRANT -> DRAIN when an accepted command (app_en&app_rdy) has c_cmd_last[g] set, or when the grant command counter reaches Max_Grant_Cmds.
  - DRAIN: command path blocked (app_en=0); write-data path stays open until the pending write counter reaches 0, then go to RELEASE.
  - RELEASE: one cycle, grant dropped, rr pointer = g+1 mod NUM_CLIENTS, then IDLE.
- Pending write counter: +1 per accepted write command, -1 per accepted app_wdf_end; both in the same cycle = no change. The width must hold 2*Max_Grant_Cmds.
- Grant command counter: cleared on grant, +1 per accepted command.
- Tag FIFO: push g on each accepted read command (app_cmd==1).
  - When full, app_en is masked to 0 for read commands only and c_app_rdy[g]=0.
  - Pop on app_rd_data_valid & app_rd_data_end.
  - c_rd_data_valid/c_rd_data_end go to the client at the FIFO head; all others are 0.
  - Push and pop in the same cycle while full are allowed; occupancy is unchanged.
- Read return is independent of grant: data for a previous owner is routed correctly while another client holds the grant.
- Read data while the FIFO is empty: no client valid, err_orphan_rd set until reset.
- c_req dropped mid-grant: ignored; the grant ends only via c_cmd_last or the Max_Grant_Cmds limit.
- init_calib falling mid-grant: the current burst completes; no new grant is issued.
- Reset mid-operation: all outstanding tags are discarded; MIG reset is the system's responsibility.

Decomposition:
- Package mig_arb_pkg holds:
  - FSM enum {IDLE, GRANT, DRAIN, RELEASE}
  - MIG command constants CMD_WR=3'd0, CMD_RD=3'd1
  - a client-index width function clog2(NUM_CLIENTS)
- Sub-module mig_arb_tag_fifo: synchronous FIFO of client indices with full/empty and simultaneous push/pop, depth Tag_Fifo_Depth.

Test Plan:
- Single client 0 writes a 4-command burst with last on the 4th, data lagging 3 cycles -> grant held through DRAIN, released after the 4th wdf_end; app sees 4 cmds and 4 data beats.
- Both clients requesting continuously, 2-command bursts -> grants alternate 0,1,0,1; one idle gap cycle (RELEASE) plus one arbitration cycle between grants.
- Client 0 issues 3 reads, then client 1 is granted and issues 2 reads; memory returns 5 beats late -> first 3 valid to client 0, next 2 to client 1.
- Tag_Fifo_Depth=4 with 6 reads outstanding and no returns -> only 4 accepted and c_app_rdy low; first return frees a slot and the 5th is accepted the same cycle.
- Client never asserts last, Max_Grant_Cmds=8 -> forced DRAIN after the 8th accepted command; the other requester is granted next.
- app_rd_data_valid pulse with no reads issued -> err_orphan_rd=1 and stays 1; all c_rd_data_valid=0.
